bus_transfer_sequencer: RTL and testbench

Sequential decoder that turns a register-transfer request (5-bit source code, 5-bit destination code) into glitch-free one-hot bus out-enables and register in-enables for the processor datapath. It is the driving end of the bus-select path. `src_oe` uses the same code ordering that the bus select encoder converts back into its 5-bit mux select, so a `src_sel` value reappears unchanged at the bus mux. A small FSM holds the source on the bus for a programmable settle time before strobing the destination, then reports completion.

---
 rtl/bus_transfer_sequencer_if.sv | 22 ++
 rtl/bus_transfer_sequencer.sv | 99 +++++++++
 tb/tb_bus_transfer_sequencer.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/bus_transfer_sequencer_if.sv
// Request/enable bundle between a transfer issuer and the bus transfer sequencer.
// Clock and reset stay outside the bundle as plain ports.
interface bus_transfer_sequencer_if;
   logic        req_valid;
   logic        req_ready;
   logic [4:0]  src_sel;
   logic [4:0]  dst_sel;
   logic [23:0] src_oe;
   logic [23:0] dst_we;
   logic        done;
   logic        err;

   modport master (
      output req_valid, src_sel, dst_sel,
      input  req_ready, src_oe, dst_we, done, err
   );

   modport slave (
      input  req_valid, src_sel, dst_sel,
      output req_ready, src_oe, dst_we, done, err
   );
endinterface

// File: rtl/bus_transfer_sequencer.sv
// Turns a (source, destination) transfer request into registered one-hot bus
// out-enables and register in-enables, holding the source for a settle time.
module bus_transfer_sequencer #(
   parameter int unsigned SETTLE_CYCLES = 1
) (
   input  logic                     clock,
   input  logic                     clear,
   bus_transfer_sequencer_if.slave  bus
);

   localparam logic [2:0] SETTLE = 3'(SETTLE_CYCLES);
   localparam logic [4:0] MAX_CODE = 5'd23;

   typedef enum logic [1:0] {IDLE, DRIVE, LATCH} state_t;

   state_t      state, state_d;
   logic [2:0]  cnt, cnt_d;
   logic [4:0]  src_q, src_d;
   logic [4:0]  dst_q, dst_d;
   logic [23:0] src_oe_d, dst_we_d;
   logic        done_d, err_d, ready_d;
   logic        accept, illegal;

   function automatic logic [23:0] onehot(input logic [4:0] code);
      return 24'b1 << code;
   endfunction

   assign accept  = bus.req_valid && bus.req_ready;
   assign illegal = (bus.src_sel > MAX_CODE) || (bus.dst_sel > MAX_CODE);

   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
      state_d = state;
      cnt_d   = cnt;
      src_d   = src_q;
      dst_d   = dst_q;
      err_d   = 1'b0;

      unique case (state)
         IDLE: begin
            if (accept) begin
               if (illegal) begin
                  err_d = 1'b1;
               end else begin
                  src_d   = bus.src_sel;
                  dst_d   = bus.dst_sel;
                  cnt_d   = SETTLE;
                  state_d = (SETTLE == 3'd0) ? LATCH : DRIVE;
               end
            end
         end
         DRIVE: begin
            cnt_d = cnt - 3'd1;
            if (cnt <= 3'd1) state_d = LATCH;
         end
         LATCH: begin
            cnt_d   = 3'd0;
            state_d = IDLE;
         end
         default: begin
            cnt_d   = 3'd0;
            state_d = IDLE;
         end
      endcase

      // Outputs are decoded from the next state so they can be registered
      // without adding a cycle of latency.
      src_oe_d = (state_d != IDLE)  ? onehot(src_d) : '0;
      dst_we_d = (state_d == LATCH) ? onehot(dst_d) : '0;
      done_d   = (state == LATCH);
      ready_d  = (state_d == IDLE);
   end

   // NOTE: state and output registers use non-blocking assignments so all update together at the edge.
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state         <= IDLE;
         cnt           <= '0;
         src_q         <= '0;
         dst_q         <= '0;
         bus.src_oe    <= '0;
         bus.dst_we    <= '0;
         bus.done      <= 1'b0;
         bus.err       <= 1'b0;
         bus.req_ready <= 1'b0;
      end else begin
         state         <= state_d;
         cnt           <= cnt_d;
         src_q         <= src_d;
         dst_q         <= dst_d;
         bus.src_oe    <= src_oe_d;
         bus.dst_we    <= dst_we_d;
         bus.done      <= done_d;
         bus.err       <= err_d;
         bus.req_ready <= ready_d;
      end
   end

endmodule

// File: tb/tb_bus_transfer_sequencer.sv
// Self-checking bench: three sequencers (settle 0, 1, 7) driven cycle by cycle;
// expected per-cycle outputs are queued at drive time and compared at the falling edge.
module tb_bus_transfer_sequencer;

   typedef struct packed {
      logic [23:0] so;
      logic [23:0] dw;
      logic        dn;
      logic        er;
      logic        rdy;
      logic [31:0] id;
   } exp_t;

   typedef struct packed {
      logic [3:0]  unit;
      logic [4:0]  src;
      logic [4:0]  dst;
      logic [23:0] so;
      logic [23:0] dw;
      logic        b2b;
      logic        scr;
   } vec_t;

   logic clock = 1'b0;
   logic clear = 1'b1;
   always #5 clock = ~clock;

   bus_transfer_sequencer_if b0 ();
   bus_transfer_sequencer_if b1 ();
   bus_transfer_sequencer_if b7 ();

   bus_transfer_sequencer #(.SETTLE_CYCLES(0)) dut0 (.clock(clock), .clear(clear), .bus(b0));
   bus_transfer_sequencer #(.SETTLE_CYCLES(1)) dut1 (.clock(clock), .clear(clear), .bus(b1));
   bus_transfer_sequencer #(.SETTLE_CYCLES(7)) dut7 (.clock(clock), .clear(clear), .bus(b7));

   exp_t q0[$];
   exp_t q1[$];
   exp_t q7[$];
   exp_t e0, e1, e7;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   step     = 0;

   function automatic exp_t mk(input logic [23:0] so, input logic [23:0] dw,
                               input logic dn, input logic er, input logic rdy);
      exp_t e;
      e.so = so; e.dw = dw; e.dn = dn; e.er = er; e.rdy = rdy; e.id = 32'(step);
      return e;
   endfunction

   task automatic check_cycle(input int unit, input exp_t e, input logic [23:0] so,
                              input logic [23:0] dw, input logic dn, input logic er,
                              input logic rdy);
      n_checks++;
      if (so !== e.so || dw !== e.dw || dn !== e.dn || er !== e.er || rdy !== e.rdy) begin
         n_fail++;
         $display("FAIL out_u%0d step %0d: got oe=%h we=%h done=%b err=%b rdy=%b, want oe=%h we=%h done=%b err=%b rdy=%b",
                  unit, e.id, so, dw, dn, er, rdy, e.so, e.dw, e.dn, e.er, e.rdy);
      end
      n_checks++;
      if ($countones(so) > 1 || $countones(dw) > 1) begin
         n_fail++;
         $display("FAIL onehot_u%0d step %0d: got oe=%h we=%h, want at most one bit each",
                  unit, e.id, so, dw);
      end
      n_checks++;
      if (dw != '0 && so == '0) begin
         n_fail++;
         $display("FAIL we_without_oe_u%0d step %0d: got we=%h with oe=%h, want oe nonzero",
                  unit, e.id, dw, so);
      end
   endtask

   always @(negedge clock) begin
      if (q0.size() > 0) begin
         e0 = q0.pop_front();
         check_cycle(0, e0, b0.src_oe, b0.dst_we, b0.done, b0.err, b0.req_ready);
      end
      if (q1.size() > 0) begin
         e1 = q1.pop_front();
         check_cycle(1, e1, b1.src_oe, b1.dst_we, b1.done, b1.err, b1.req_ready);
      end
      if (q7.size() > 0) begin
         e7 = q7.pop_front();
         check_cycle(7, e7, b7.src_oe, b7.dst_we, b7.done, b7.err, b7.req_ready);
      end
   end

   // One cycle of stimulus on one unit, plus the outputs expected in that cycle.
   task automatic drive(input int unit, input logic v, input logic [4:0] s,
                        input logic [4:0] d, input exp_t e);
      @(posedge clock);
      #1;
      step++;
      case (unit)
         0:       begin b0.req_valid = v; b0.src_sel = s; b0.dst_sel = d; q0.push_back(e); end
         1:       begin b1.req_valid = v; b1.src_sel = s; b1.dst_sel = d; q1.push_back(e); end
         default: begin b7.req_valid = v; b7.src_sel = s; b7.dst_sel = d; q7.push_back(e); end
      endcase
   endtask

   // Cycles 0..S+1 of a legal transfer; the caller supplies the done cycle.
   task automatic xfer(input vec_t v, input logic prev_done);
      int          s;
      logic [4:0]  rs, rd;
      logic        rv;
      s = int'(v.unit);
      drive(s, 1'b1, v.src, v.dst, mk('0, '0, prev_done, 1'b0, 1'b1));
      for (int c = 1; c <= s + 1; c++) begin
         rs = v.scr ? 5'($urandom) : v.src;
         rd = v.scr ? 5'($urandom) : v.dst;
         rv = v.scr ? 1'($urandom) : 1'b0;
         drive(s, rv, rs, rd, mk(v.so, (c == s + 1) ? v.dw : 24'h0, 1'b0, 1'b0, 1'b0));
      end
   endtask

   vec_t tbl [7];
   vec_t post;

   initial begin
      //        unit  src    dst    src_oe      dst_we      b2b  scr
      tbl[0] = {4'd1, 5'd23, 5'd5,  24'h800000, 24'h000020, 1'b0, 1'b0};
      tbl[1] = {4'd0, 5'd2,  5'd21, 24'h000004, 24'h200000, 1'b0, 1'b0};
      tbl[2] = {4'd0, 5'd3,  5'd20, 24'h000008, 24'h100000, 1'b1, 1'b0};
      tbl[3] = {4'd1, 5'd20, 5'd3,  24'h100000, 24'h000008, 1'b0, 1'b1};
      tbl[4] = {4'd7, 5'd7,  5'd16, 24'h000080, 24'h010000, 1'b0, 1'b1};
      tbl[5] = {4'd1, 5'd8,  5'd23, 24'h000100, 24'h800000, 1'b0, 1'b0};
      tbl[6] = {4'd1, 5'd0,  5'd0,  24'h000001, 24'h000001, 1'b0, 1'b0};
      post   = {4'd7, 5'd12, 5'd9,  24'h001000, 24'h000200, 1'b0, 1'b0};

      b0.req_valid = 1'b0; b0.src_sel = '0; b0.dst_sel = '0;
      b1.req_valid = 1'b0; b1.src_sel = '0; b1.dst_sel = '0;
      b7.req_valid = 1'b0; b7.src_sel = '0; b7.dst_sel = '0;

      // Reset held for three cycles with a request pending.
      #2 clear = 1'b0;
      repeat (3) drive(1, 1'b1, 5'd3, 5'd4, mk('0, '0, 1'b0, 1'b0, 1'b0));
      @(posedge clock);
      #1;
      clear = 1'b1;
      b1.req_valid = 1'b0;
      step++;
      q1.push_back(mk('0, '0, 1'b0, 1'b0, 1'b0));
      repeat (2) drive(1, 1'b0, 5'd3, 5'd4, mk('0, '0, 1'b0, 1'b0, 1'b1));

      // Table of legal transfers; a b2b entry is accepted in the previous done cycle.
      for (int i = 0; i < 7; i++) begin
         xfer(tbl[i], tbl[i].b2b);
         if (i == 6 || !tbl[i + 1].b2b)
            drive(int'(tbl[i].unit), 1'b0, '0, '0, mk('0, '0, 1'b1, 1'b0, 1'b1));
      end

      // Two illegal requests back to back, then a legal one in the err cycle.
      drive(1, 1'b1, 5'd24, 5'd0,  mk('0, '0, 1'b0, 1'b0, 1'b1));
      drive(1, 1'b1, 5'd0,  5'd31, mk('0, '0, 1'b0, 1'b1, 1'b1));
      drive(1, 1'b1, 5'd5,  5'd10, mk('0, '0, 1'b0, 1'b1, 1'b1));
      drive(1, 1'b0, 5'd0,  5'd0,  mk(24'h000020, '0, 1'b0, 1'b0, 1'b0));
      drive(1, 1'b0, 5'd0,  5'd0,  mk(24'h000020, 24'h000400, 1'b0, 1'b0, 1'b0));
      drive(1, 1'b0, 5'd0,  5'd0,  mk('0, '0, 1'b1, 1'b0, 1'b1));
      drive(1, 1'b0, 5'd0,  5'd0,  mk('0, '0, 1'b0, 1'b0, 1'b1));

      // Reset in cycle 4 of a settle-7 transfer aborts it.
      drive(7, 1'b1, 5'd12, 5'd9, mk('0, '0, 1'b0, 1'b0, 1'b1));
      repeat (3) drive(7, 1'b0, 5'd0, 5'd0, mk(24'h001000, '0, 1'b0, 1'b0, 1'b0));
      @(posedge clock);
      #1;
      clear = 1'b0;
      step++;
      q7.push_back(mk('0, '0, 1'b0, 1'b0, 1'b0));
      drive(7, 1'b0, 5'd0, 5'd0, mk('0, '0, 1'b0, 1'b0, 1'b0));
      @(posedge clock);
      #1;
      clear = 1'b1;
      step++;
      q7.push_back(mk('0, '0, 1'b0, 1'b0, 1'b0));
      xfer(post, 1'b0);
      drive(7, 1'b0, '0, '0, mk('0, '0, 1'b1, 1'b0, 1'b1));
      drive(7, 1'b0, '0, '0, mk('0, '0, 1'b0, 1'b0, 1'b1));

      repeat (2) @(posedge clock);
      n_checks++;
      if (q0.size() + q1.size() + q7.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending expectations, want 0",
                  q0.size() + q1.size() + q7.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion by time limit, want finish");
      $fatal(1, "watchdog expired");
   end

endmodule
